// File: rtl/btb_ctrl_if.sv
// Branch-target-buffer port bundle: fetch-side lookup, execute-side update, flush and status.
// master drives requests (fetch/execute/control); slave is the BTB controller.
interface btb_ctrl_if;
    localparam int unsigned PC_W = 32;

    logic            flush;
    logic [PC_W-1:0] lookup_pc;
    logic            pred_hit;
    logic            pred_taken;
    logic [PC_W-1:0] pred_target;
    logic            upd_en;
    logic [PC_W-1:0] upd_pc;
    logic            upd_taken;
    logic [PC_W-1:0] upd_target;
    logic            busy;

    modport master (
        output flush, lookup_pc, upd_en, upd_pc, upd_taken, upd_target,
        input  pred_hit, pred_taken, pred_target, busy
    );

    modport slave (
        input  flush, lookup_pc, upd_en, upd_pc, upd_taken, upd_target,
        output pred_hit, pred_taken, pred_target, busy
    );
endinterface

// File: rtl/btb_ctrl.sv
// Direct-mapped branch target buffer with 2-bit direction counters.
// Combinational lookup; table is swept clear one entry per cycle after reset or flush.
module btb_ctrl #(
    parameter int unsigned IDX_W = 4
) (
    input  logic       CLK,
    input  logic       nRST,
    btb_ctrl_if.slave  bus
);
    localparam int unsigned ENTRIES = 1 << IDX_W;
    localparam int unsigned TAG_W   = 32 - IDX_W - 2;

    localparam logic [0:0] ST_INIT  = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [31:0]      target;
        logic [1:0]       ctr;
    } entry_t;

    logic [0:0]       state_q;
    logic [0:0]       state_d;
    logic [IDX_W-1:0] sweep_q;
    logic [IDX_W-1:0] sweep_d;
    entry_t           tbl_q [ENTRIES];

    logic             ready;
    logic [IDX_W-1:0] l_idx;
    logic [TAG_W-1:0] l_tag;
    logic             l_hit;
    logic             l_taken;
    logic [IDX_W-1:0] u_idx;
    logic [TAG_W-1:0] u_tag;
    logic             u_hit;
    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    entry_t           wr_data;

    // Byte offset within the instruction word never participates in indexing or tagging.
    logic unused_pc_lsbs;
    assign unused_pc_lsbs = ^{bus.lookup_pc[1:0], bus.upd_pc[1:0]};

    // Encoding: 00 SNT, 01 WNT, 11 ST, 10 WT; bit 1 is the predicted direction.
    function automatic logic [1:0] ctr_next(input logic [1:0] c, input logic taken);
        logic [1:0] n;
        case (c)
            2'b00:   n = taken ? 2'b01 : 2'b00;
            2'b01:   n = taken ? 2'b11 : 2'b00;
            2'b11:   n = taken ? 2'b11 : 2'b10;
            default: n = taken ? 2'b11 : 2'b00;
        endcase
        return n;
    endfunction

    assign ready = (state_q == ST_READY);
    assign l_idx = bus.lookup_pc[IDX_W+1:2];
    assign l_tag = bus.lookup_pc[31:IDX_W+2];
    assign u_idx = bus.upd_pc[IDX_W+1:2];
    assign u_tag = bus.upd_pc[31:IDX_W+2];

    // Lookup is masked until the sweep completes, so stale or unreset contents never leak.
    assign l_hit   = ready && tbl_q[l_idx].valid && (tbl_q[l_idx].tag == l_tag);
    assign l_taken = l_hit && tbl_q[l_idx].ctr[1];
    assign u_hit   = tbl_q[u_idx].valid && (tbl_q[u_idx].tag == u_tag);

    assign bus.pred_hit    = l_hit;
    assign bus.pred_taken  = l_taken;
    assign bus.pred_target = l_taken ? tbl_q[l_idx].target : 32'h0;
    assign bus.busy        = (state_q == ST_INIT);

    // Controller next state: flush always wins and restarts the sweep.
    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        if (bus.flush) begin
            state_d = ST_INIT;
            sweep_d = '0;
        end else if (state_q == ST_INIT) begin
            if (sweep_q == IDX_W'(ENTRIES - 1)) begin
                state_d = ST_READY;
                sweep_d = '0;
            end else begin
                sweep_d = sweep_q + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= ST_INIT;
            sweep_q <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
        end
    end

    // Single table write port: sweep clear while initialising, otherwise resolved-branch update.
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = sweep_q;
        wr_data = '0;
        if (state_q == ST_INIT) begin
            wr_en = 1'b1;
        end else if (bus.upd_en && !bus.flush) begin
            wr_idx = u_idx;
            if (u_hit) begin
                wr_en       = 1'b1;
                wr_data     = tbl_q[u_idx];
                wr_data.ctr = ctr_next(tbl_q[u_idx].ctr, bus.upd_taken);
                if (bus.upd_taken) begin
                    wr_data.target = bus.upd_target;
                end
            end else if (bus.upd_taken) begin
                wr_en          = 1'b1;
                wr_data.valid  = 1'b1;
                wr_data.tag    = u_tag;
                wr_data.target = bus.upd_target;
                wr_data.ctr    = 2'b10;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            tbl_q[wr_idx] <= wr_data;
        end
    end
endmodule
